// File: rtl/rnd_responder_pkg.sv
// Shared constants, state encoding and LFSR step for the random-number responder.
package rnd_responder_pkg;

  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] DEF_SEED_INIT = 16'hACE1;

  typedef enum logic [3:0] {
    StIdle   = 4'b0001,
    StShift  = 4'b0010,
    StReduce = 4'b0100,
    StDone   = 4'b1000
  } state_e;

  // Right-shifting Galois LFSR; maximal length, so a nonzero state never reaches zero.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/rnd_responder_if.sv
// Start_rnd/Done_rnd handshake between the controller (master) and the responder (slave).
interface rnd_responder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             seed_load;
  logic [15:0]      seed;
  logic [WIDTH-1:0] limit;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] rnd_out;

  modport master (
    output start, seed_load, seed, limit,
    input  busy, done, rnd_out
  );

  modport slave (
    input  start, seed_load, seed, limit,
    output busy, done, rnd_out
  );
endinterface

// File: rtl/rnd_remainder.sv
// Serial restoring remainder: one dividend bit per step, MSB first, WIDTH steps per result.
module rnd_remainder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             valid,
  output logic [WIDTH-1:0] result
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_nx;
  logic             sub;

  always_comb begin
    rem_sh = {rem_q, dvd_q[WIDTH-1]};
    // A zero divisor never subtracts, so the dividend shifts through untouched.
    sub    = (divisor != '0) && (rem_sh >= {1'b0, divisor});
    rem_nx = sub ? (rem_sh[WIDTH-1:0] - divisor) : rem_sh[WIDTH-1:0];
    result = rem_nx;
    valid  = step && (cnt_q == CntW'(WIDTH - 1));

    dvd_d = dvd_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    if (load) begin
      dvd_d = dividend;
      rem_d = '0;
      cnt_d = '0;
    end else if (step) begin
      dvd_d = dvd_q << 1;
      rem_d = rem_nx;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rnd_responder.sv
// Responder for the controller's random-number request: LFSR advance, modulo reduce, done level.
module rnd_responder
  import rnd_responder_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STEPS    = 4,
  parameter logic [15:0] DEF_SEED = DEF_SEED_INIT
) (
  input  logic           clk,
  input  logic           rst,
  rnd_responder_if.slave bus
);

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [7:0]       step_q, step_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rnd_q, rnd_d;

  logic             rem_load;
  logic             rem_step;
  logic             rem_valid;
  logic [WIDTH-1:0] rem_result;

  rnd_remainder #(
    .WIDTH(WIDTH)
  ) u_rem (
    .clk      (clk),
    .rst      (rst),
    .load     (rem_load),
    .step     (rem_step),
    .dividend (lfsr_d[WIDTH-1:0]),
    .divisor  (lim_q),
    .valid    (rem_valid),
    .result   (rem_result)
  );

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    lim_d    = lim_q;
    step_d   = step_q;
    done_d   = done_q;
    rnd_d    = rnd_q;
    rem_load = 1'b0;
    rem_step = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        // Seed lands before the request is taken, so SHIFT runs from the new seed.
        if (bus.seed_load) begin
          lfsr_d = (bus.seed == 16'h0000) ? DEF_SEED : bus.seed;
        end
        if (bus.start) begin
          lim_d   = bus.limit;
          step_d  = 8'd0;
          done_d  = 1'b0;
          state_d = StShift;
        end
      end
      StShift: begin
        lfsr_d = lfsr_step(lfsr_q);
        step_d = step_q + 8'd1;
        if (step_q == 8'(STEPS - 1)) begin
          rem_load = 1'b1;
          state_d  = StReduce;
        end
      end
      StReduce: begin
        rem_step = 1'b1;
        if (rem_valid) begin
          rnd_d   = rem_result;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      lfsr_q  <= DEF_SEED;
      lim_q   <= '0;
      step_q  <= 8'd0;
      done_q  <= 1'b0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      lim_q   <= lim_d;
      step_q  <= step_d;
      done_q  <= done_d;
      rnd_q   <= rnd_d;
    end
  end

  assign bus.busy    = (state_q == StShift) || (state_q == StReduce);
  assign bus.done    = done_q;
  assign bus.rnd_out = rnd_q;

endmodule

// File: tb/tb_rnd_responder.sv
// Scoreboard bench for rnd_responder: requests push expectations, a monitor checks each done rise.
module tb_rnd_responder;
  localparam int unsigned W     = 8;
  localparam int unsigned STEPS = 1;
  localparam int unsigned LAT   = STEPS + W;

  typedef struct {
    logic [7:0]  val;
    logic [7:0]  lim;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        done_prev = 1'b0;
  exp_t        sb[$];
  logic [15:0] mdl;
  logic [7:0]  lims [5] = '{8'd10, 8'd7, 8'd200, 8'd1, 8'd255};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rnd_responder_if #(.WIDTH(W)) bus ();

  rnd_responder #(
    .WIDTH(W),
    .STEPS(STEPS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && bus.done && !done_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rnd_out", {24'd0, bus.rnd_out}, {24'd0, e.val});
        chk("latency", cyc, e.cyc);
        if (e.lim != 8'd0) chk("below_limit", {31'd0, bus.rnd_out < e.lim}, 32'd1);
      end
    end
    done_prev <= bus.done;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_rnd",  {24'd0, bus.rnd_out}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // poke > 0: a stray start (and seed_load) is driven that many cycles into the request.
  task automatic req(input logic [7:0] lim, input logic [7:0] expv, input int poke,
                     input logic ld, input logic [15:0] sd);
    int i;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.limit     = lim;
    bus.seed_load = ld;
    bus.seed      = sd;
    sb.push_back('{val: expv, lim: lim, cyc: cyc + 1 + LAT});
    @(negedge clk);
    bus.start     = 1'b0;
    bus.seed_load = 1'b0;
    chk("done_low_after_start", {31'd0, bus.done}, 32'd0);
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      bus.start     = 1'b1;
      bus.seed_load = 1'b1;
      bus.seed      = 16'h5555;
      @(negedge clk);
      bus.start     = 1'b0;
      bus.seed_load = 1'b0;
    end
    i = 0;
    while (!bus.done && i < 4 * LAT) begin
      @(negedge clk);
      i++;
    end
    if (!bus.done) begin
      chk("done_timeout", 32'd0, 32'd1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    bus.start     = 1'b0;
    bus.seed_load = 1'b0;
    bus.seed      = 16'h0000;
    bus.limit     = 8'd0;
    #1 rst = 1'b0;
    #1;
    chk("por_done", {31'd0, bus.done}, 32'd0);
    chk("por_busy", {31'd0, bus.busy}, 32'd0);
    chk("por_rnd",  {24'd0, bus.rnd_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // From reset: ACE1 -> E270 (raw 112), then 7138 (raw 56).
    req(8'd10, 8'd2, 0, 1'b0, 16'h0000);
    req(8'd10, 8'd6, 0, 1'b0, 16'h0000);

    do_reset();
    req(8'd0, 8'd112, 0, 1'b0, 16'h0000);

    // Zero seed in DONE restores the default seed and leaves the result untouched.
    @(negedge clk);
    bus.seed_load = 1'b1;
    bus.seed      = 16'h0000;
    @(negedge clk);
    bus.seed_load = 1'b0;
    chk("seed_load_keeps_done", {31'd0, bus.done}, 32'd1);
    chk("seed_load_keeps_rnd", {24'd0, bus.rnd_out}, 32'd112);
    req(8'd10, 8'd2, 0, 1'b0, 16'h0000);

    // Stray start/seed_load in REDUCE: 7138 raw 56 mod 9 = 2; next 389C raw 156.
    req(8'd9, 8'd2, 2, 1'b0, 16'h0000);
    req(8'd0, 8'd156, 0, 1'b0, 16'h0000);

    // Reset while in SHIFT.
    @(negedge clk);
    bus.start = 1'b1;
    bus.limit = 8'd10;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_rnd",  {24'd0, bus.rnd_out}, 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req(8'd10, 8'd2, 0, 1'b0, 16'h0000);

    // Seed and start together: 1234 -> 091A, raw 26 mod 5 = 1.
    req(8'd5, 8'd1, 0, 1'b1, 16'h1234);

    // Controller loop against a reference LFSR model.
    do_reset();
    mdl = 16'hACE1;
    for (int k = 0; k < 5; k++) begin
      for (int s = 0; s < int'(STEPS); s++) mdl = (mdl >> 1) ^ (mdl[0] ? 16'hB400 : 16'h0000);
      req(lims[k], mdl[7:0] % lims[k], 0, 1'b0, 16'h0000);
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
